// File: rtl/clock_key_frontend.sv
`timescale 1ns/1ps
// clock_key_frontend: sync, debounce and press detection for five keys plus set-mode control.
// Define CLOCK_KEY_AUTO_REPEAT_EN to enable inc/dec auto-repeat.
module clock_key_frontend #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode_n,
  input  logic       key_sel_n,
  input  logic       key_field_n,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  output logic       set_mode,
  output logic       sel,
  output logic [1:0] set_select,
  output logic       inc_pulse,
  output logic       dec_pulse
);

  localparam int NK = 5;
  localparam int KM = 0;
  localparam int KS = 1;
  localparam int KF = 2;
  localparam int KI = 3;
  localparam int KD = 4;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1)
  begin : g_param_chk
    $error("clock_key_frontend: cycle parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT,
    S_LOCK
  } state_t;

  logic [NK-1:0] w_raw;
  logic [NK-1:0] r_sync1;
  logic [NK-1:0] r_sync2;
  logic [NK-1:0] r_stable;
  logic [NK-1:0] r_evt;
  logic [DW-1:0] r_dcnt [NK];

  logic       r_set_mode;
  logic       r_sel;
  logic [1:0] r_set_select;

  state_t r_state;
  state_t w_next;
  logic   r_hold_dec;
  logic   r_inc_pulse;
  logic   r_dec_pulse;
  logic   w_start;
  logic   w_fire;
  logic   w_fire_dec;

  logic w_mode_evt;
  logic w_sel_evt;
  logic w_field_evt;
  logic w_inc_evt;
  logic w_dec_evt;
  logic w_inc_held;
  logic w_dec_held;
  logic w_both;
  logic w_mode_fall;
  logic w_key_rel;

  assign w_raw = {key_dec_n, key_inc_n, key_field_n,
                  key_sel_n, key_mode_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Stable level flips after DEBOUNCE_CYCLES+1 consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= '1;
      r_evt    <= '0;
      for (int k = 0; k < NK; k++) r_dcnt[k] <= '0;
    end else begin
      for (int k = 0; k < NK; k++) begin
        r_evt[k] <= 1'b0;
        if (r_sync2[k] == r_stable[k]) begin
          r_dcnt[k] <= '0;
        end else if (r_dcnt[k] == DMAX) begin
          r_dcnt[k]   <= '0;
          r_stable[k] <= r_sync2[k];
          r_evt[k]    <= ~r_sync2[k];
        end else begin
          r_dcnt[k] <= r_dcnt[k] + DW'(1);
        end
      end
    end
  end

  assign w_mode_evt  = r_evt[KM];
  assign w_sel_evt   = r_evt[KS];
  assign w_field_evt = r_evt[KF];
  assign w_inc_evt   = r_evt[KI];
  assign w_dec_evt   = r_evt[KD];
  assign w_inc_held  = ~r_stable[KI];
  assign w_dec_held  = ~r_stable[KD];
  assign w_both      = w_inc_held & w_dec_held;
  assign w_mode_fall = w_mode_evt & r_set_mode;
  assign w_key_rel   = r_hold_dec ? ~w_dec_held
                                  : ~w_inc_held;

  // All decisions below use the pre-toggle set_mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set_mode   <= 1'b0;
      r_sel        <= 1'b0;
      r_set_select <= 2'd0;
    end else begin
      if (w_mode_evt) r_set_mode <= ~r_set_mode;
      if (w_sel_evt) r_sel <= ~r_sel;
      if (w_mode_evt && !r_set_mode) begin
        r_set_select <= 2'd0;
      end else if (w_field_evt && r_set_mode) begin
        r_set_select <= r_set_select + 2'd1;
      end
    end
  end

`ifdef CLOCK_KEY_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE)
                        ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(RMAX + 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

  logic [CW-1:0] r_rcnt;
  logic          w_hold_done;
  logic          w_rate_done;

  assign w_hold_done = (r_rcnt == DLY_LAST);
  assign w_rate_done = (r_rcnt == RATE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt <= '0;
    end else if (w_fire ||
                 !(w_next == S_HOLD || w_next == S_REPEAT)) begin
      r_rcnt <= '0;
    end else begin
      r_rcnt <= r_rcnt + CW'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold_dec  <= 1'b0;
      r_inc_pulse <= 1'b0;
      r_dec_pulse <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) r_hold_dec <= w_dec_evt;
      r_inc_pulse <= w_fire & ~w_fire_dec;
      r_dec_pulse <= w_fire & w_fire_dec;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_mode_fall) begin
      w_next = S_IDLE;
    end else if (r_set_mode && w_both) begin
      w_next = S_LOCK;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (r_set_mode && (w_inc_evt ^ w_dec_evt))
            w_next = S_HOLD;
        end
        S_HOLD: begin
          if (w_key_rel)
            w_next = S_IDLE;
`ifdef CLOCK_KEY_AUTO_REPEAT_EN
          else if (w_hold_done)
            w_next = S_REPEAT;
`endif
        end
        S_REPEAT: begin
          if (w_key_rel)
            w_next = S_IDLE;
        end
        S_LOCK: begin
          if (!w_inc_held && !w_dec_held)
            w_next = S_IDLE;
        end
      endcase
    end
  end

  assign w_start = (r_state == S_IDLE) && (w_next == S_HOLD);

  always_comb begin
    w_fire     = 1'b0;
    w_fire_dec = r_hold_dec;
    unique case (1'b1)
      w_start: begin
        w_fire     = 1'b1;
        w_fire_dec = w_dec_evt;
      end
`ifdef CLOCK_KEY_AUTO_REPEAT_EN
      (r_state == S_HOLD && w_next == S_REPEAT): begin
        w_fire = 1'b1;
      end
      (r_state == S_REPEAT && w_next == S_REPEAT): begin
        w_fire = w_rate_done;
      end
`endif
      default: ;
    endcase
  end

  assign set_mode   = r_set_mode;
  assign sel        = r_sel;
  assign set_select = r_set_select;
  assign inc_pulse  = r_inc_pulse;
  assign dec_pulse  = r_dec_pulse;

endmodule

// File: tb/tb_clock_key_frontend.sv
`timescale 1ns/1ps
// tb_clock_key_frontend: directed plus random key stimulus
// against a cycle-level behavioural model of the key front end.
module tb_clock_key_frontend;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int KM = 0;
  localparam int KS = 1;
  localparam int KF = 2;
  localparam int KI = 3;
  localparam int KD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] keys = '1;
  logic       set_mode;
  logic       sel;
  logic [1:0] set_select;
  logic       inc_pulse;
  logic       dec_pulse;

  int n_chk  = 0;
  int n_pass = 0;
  int n_inc  = 0;
  int n_dec  = 0;

  bit [4:0] m_s1, m_s2, m_stb, m_evt;
  int       m_run [5];
  bit       m_mode, m_sel, m_lock;
  int       m_field, m_held, m_age;
  bit       e_inc, e_dec;

  always #5 clk = ~clk;

  clock_key_frontend #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_mode_n (keys[KM]),
    .key_sel_n  (keys[KS]),
    .key_field_n(keys[KF]),
    .key_inc_n  (keys[KI]),
    .key_dec_n  (keys[KD]),
    .set_mode   (set_mode),
    .sel        (sel),
    .set_select (set_select),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse)
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_s1 = '1; m_s2 = '1; m_stb = '1; m_evt = '0;
    for (int k = 0; k < 5; k++) m_run[k] = 0;
    m_mode = 0; m_sel = 0; m_lock = 0;
    m_field = 0; m_held = 0; m_age = 0;
    e_inc = 0; e_dec = 0;
  endtask

  // One clock edge: control reacts to last edge's debounced view,
  // then the debouncers take in the key level seen two edges ago.
  task automatic model_step();
    bit om, pi, pd, ie, de, rel;
    bit [4:0] seen;
    e_inc = 0; e_dec = 0;
    om = m_mode;
    pi = !m_stb[KI]; pd = !m_stb[KD];
    ie = m_evt[KI];  de = m_evt[KD];
    if (m_evt[KM]) begin
      m_mode = !m_mode;
      if (!om) m_field = 0;
    end
    if (m_evt[KS]) m_sel = !m_sel;
    if (m_evt[KF] && om) m_field = (m_field + 1) % 4;
    if (m_evt[KM] && om) begin
      m_held = 0; m_lock = 0;
    end else if (om && pi && pd) begin
      m_lock = 1; m_held = 0;
    end else if (m_lock) begin
      if (!pi && !pd) m_lock = 0;
    end else if (m_held != 0) begin
      rel = (m_held == 1) ? !pi : !pd;
      if (rel) m_held = 0;
      else begin
        m_age++;
`ifdef CLOCK_KEY_AUTO_REPEAT_EN
        if (m_age == RD ||
            (m_age > RD && (m_age - RD) % RR == 0)) begin
          e_inc = (m_held == 1);
          e_dec = (m_held == 2);
        end
`endif
      end
    end else if (om && (ie != de)) begin
      m_held = ie ? 1 : 2;
      m_age = 0;
      e_inc = ie; e_dec = de;
    end
    seen = m_s2; m_s2 = m_s1; m_s1 = keys;
    for (int k = 0; k < 5; k++) begin
      m_evt[k] = 0;
      if (seen[k] != m_stb[k]) begin
        m_run[k]++;
        if (m_run[k] == DB + 1) begin
          m_stb[k] = seen[k];
          m_run[k] = 0;
          m_evt[k] = !seen[k];
        end
      end else m_run[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step();
    #1;
    check("set_mode", set_mode, m_mode);
    check("sel", sel, m_sel);
    check("set_select", set_select, m_field);
    check("inc_pulse", inc_pulse, e_inc);
    check("dec_pulse", dec_pulse, e_dec);
    if (inc_pulse) n_inc++;
    if (dec_pulse) n_dec++;
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(int k, int hold);
    keys[k] = 1'b0;
    cyc(hold);
    keys[k] = 1'b1;
    cyc(12);
  endtask

  initial begin
    int bi, bd, exp_n;
    int exp_f [5];
    exp_f = '{1, 2, 3, 0, 1};
    model_reset();
    rst = 1'b1;
    cyc(3);
    check("rst_mode", set_mode, 0);
    check("rst_sel", sel, 0);
    check("rst_field", set_select, 0);
    check("rst_inc", inc_pulse, 0);
    check("rst_dec", dec_pulse, 0);
    rst = 1'b0;
    cyc(2);

    keys[KM] = 1'b0;
    repeat (7) @(posedge clk);
    #1 check("mode_edge6", set_mode, 0);
    @(posedge clk);
    #1 check("mode_edge7", set_mode, 1);
    check("mode_field0", set_select, 0);
    keys[KM] = 1'b1;
    cyc(12);
    tap(KM, 8);
    check("mode_second", set_mode, 0);
    tap(KM, 8);

    bi = n_inc;
    for (int i = 0; i < 5; i++) begin
      keys[KI] = 1'b0; cyc(3);
      keys[KI] = 1'b1; cyc(3);
    end
    check("bounce_none", n_inc - bi, 0);
    keys[KI] = 1'b0;
    cyc(12);
    check("bounce_one", n_inc - bi, 1);
    keys[KI] = 1'b1;
    cyc(12);

    bd = n_dec;
    keys[KD] = 1'b0;
    cyc(60);
    keys[KD] = 1'b1;
    cyc(20);
    exp_n = 1;
`ifdef CLOCK_KEY_AUTO_REPEAT_EN
    exp_n = 2 + (60 - 1 - RD) / RR;
`endif
    check("dec_hold", n_dec - bd, exp_n);
    bd = n_dec;
    cyc(20);
    check("dec_after", n_dec - bd, 0);

    for (int i = 0; i < 5; i++) begin
      tap(KF, 8);
      check("field_seq", set_select, exp_f[i]);
    end
    tap(KM, 8);
    tap(KF, 8);
    tap(KF, 8);
    check("field_idle", set_select, 1);
    tap(KM, 8);
    check("field_reenter", set_select, 0);

    bi = n_inc; bd = n_dec;
    keys[KI] = 1'b0; keys[KD] = 1'b0;
    cyc(15);
    keys[KD] = 1'b1;
    cyc(15);
    check("lock_one_held", (n_inc - bi) + (n_dec - bd), 0);
    keys[KI] = 1'b1;
    cyc(12);
    check("lock_none", (n_inc - bi) + (n_dec - bd), 0);
    tap(KI, 8);
    check("lock_after", n_inc - bi, 1);

    bi = n_inc;
    keys[KI] = 1'b0;
    cyc(60);
    keys[KI] = 1'b1;
    cyc(12);
    check("inc_hold", n_inc - bi, exp_n);

    keys[KI] = 1'b0;
    cyc(10);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("midrst_mode", set_mode, 0);
    check("midrst_field", set_select, 0);
    check("midrst_inc", inc_pulse, 0);
    bi = n_inc;
    cyc(3);
    rst = 1'b0;
    cyc(20);
    check("midrst_nopulse", n_inc - bi, 0);
    keys[KI] = 1'b1;
    cyc(12);

    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(0, 99) < ((k >= KI) ? 3 : 6))
          keys[k] = ~keys[k];
      end
      rst = ($urandom_range(0, 1999) == 0);
      cyc(1);
    end
    rst = 1'b0;
    keys = '1;
    cyc(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
